// File: rtl/rhs_pkg.sv
// rtl/rhs_pkg.sv - shared types and constants for the RHS headstage SPI path
// Frame width, master FSM states and the RHS command opcodes used by the sequencer.
package rhs_pkg;

   localparam int FRAME_BITS = 32;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   localparam logic [1:0] OP_CONVERT = 2'b00;
   localparam logic [1:0] OP_WRITE   = 2'b10;
   localparam logic [1:0] OP_READ    = 2'b11;
   localparam logic [7:0] OP_CLEAR   = 8'h6A;

   // Opcode in the top bits, register address in [23:16], payload in [15:0].
   function automatic logic [FRAME_BITS-1:0] rhs_cmd(input logic [1:0] op,
                                                     input logic [7:0] addr,
                                                     input logic [15:0] data);
      return {op, 6'b000000, addr, data};
   endfunction

endpackage

// File: rtl/rhs_sclk_gen.sv
// rtl/rhs_sclk_gen.sv - SCLK generator for the RHS SPI master
// Toggles SCLK every HALF clk cycles while enabled; rise/fall mark the edge that changes SCLK.
module rhs_sclk_gen #(
   parameter int HALF = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int PH_W = (HALF > 1) ? $clog2(HALF) : 1;

   logic [PH_W-1:0] phase;
   logic            tick;

   assign tick = en && (phase == PH_W'(HALF - 1));
   assign rise = tick && !sclk;
   assign fall = tick && sclk;

   // Disabling parks SCLK low with the phase counter cleared, so every frame starts aligned.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         phase <= '0;
         sclk  <= 1'b0;
      end else if (tick) begin
         phase <= '0;
         sclk  <= ~sclk;
      end else begin
         phase <= phase + 1'b1;
      end
   end

endmodule

// File: rtl/rhs_spi_master.sv
// rtl/rhs_spi_master.sv - 32-bit SPI master for one RHS headstage
// One start yields one CS-framed 32-bit exchange; result returned with a done pulse.
module rhs_spi_master
   import rhs_pkg::*;
#(
   parameter int CLK_DIV        = 4,
   parameter int CS_HIGH_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [FRAME_BITS-1:0] cmd,
   output logic                  busy,
   output logic                  done,
   output logic [FRAME_BITS-1:0] rx_data,
   output logic                  CS,
   output logic                  SCLK,
   output logic                  MOSI,
   input  logic                  MISO
);

   localparam int H       = CLK_DIV / 2;
   localparam int CNT_MAX = (H > CS_HIGH_CYCLES) ? H : CS_HIGH_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t                state;
   logic [5:0]            bit_cnt;
   logic [CNT_W-1:0]      cnt;
   logic [FRAME_BITS-2:0] tx_sr;
   logic [FRAME_BITS-1:0] rx_sr;
   logic                  sclk_en;
   logic                  sclk_rise;
   logic                  sclk_fall;

   assign sclk_en = (state == SETUP) || (state == SHIFT);

   rhs_sclk_gen #(
      .HALF(H)
   ) u_sclk (
      .clk  (clk),
      .rst  (rst),
      .en   (sclk_en),
      .sclk (SCLK),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         cnt     <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         rx_data <= '0;
         CS      <= 1'b1;
         MOSI    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state   <= SETUP;
                  tx_sr   <= cmd[FRAME_BITS-2:0];
                  MOSI    <= cmd[FRAME_BITS-1];
                  CS      <= 1'b0;
                  busy    <= 1'b1;
                  bit_cnt <= '0;
                  rx_sr   <= '0;
               end
            end
            SETUP: begin
               if (sclk_rise) state <= SHIFT;
            end
            SHIFT: begin
               // MISO is sampled and MOSI advanced on the same edge that drops SCLK.
               if (sclk_fall) begin
                  rx_sr <= {rx_sr[FRAME_BITS-2:0], MISO};
                  if (bit_cnt == 6'(FRAME_BITS - 1)) begin
                     state <= HOLD;
                     cnt   <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     MOSI    <= tx_sr[FRAME_BITS-2];
                     tx_sr   <= {tx_sr[FRAME_BITS-3:0], 1'b0};
                  end
               end
            end
            HOLD: begin
               if (cnt == CNT_W'(H - 1)) begin
                  state   <= GAP;
                  cnt     <= '0;
                  CS      <= 1'b1;
                  MOSI    <= 1'b0;
                  done    <= 1'b1;
                  rx_data <= rx_sr;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               if (cnt == CNT_W'(CS_HIGH_CYCLES - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rhs_spi_master.sv
// tb/tb_rhs_spi_master.sv - self-checking bench for rhs_spi_master
// Two instances: default timing with bench-driven MISO, and CLK_DIV=2/CS_HIGH_CYCLES=1 in loopback.
module tb_rhs_spi_master;

   localparam int H1   = 2;
   localparam int CSH1 = 8;
   localparam int H2   = 1;
   localparam int CSH2 = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        start1, start2;
   logic [31:0] cmd1, cmd2;
   logic        busy1, busy2, done1, done2;
   logic [31:0] rx_data1, rx_data2;
   logic        CS1, CS2, SCLK1, SCLK2, MOSI1, MOSI2;
   logic        MISO1 = 1'b0;
   logic        MISO2;
   logic [31:0] miso_word1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign MISO2 = MOSI2;

   rhs_spi_master #(.CLK_DIV(2*H1), .CS_HIGH_CYCLES(CSH1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .cmd(cmd1), .busy(busy1), .done(done1),
      .rx_data(rx_data1), .CS(CS1), .SCLK(SCLK1), .MOSI(MOSI1), .MISO(MISO1));

   rhs_spi_master #(.CLK_DIV(2*H2), .CS_HIGH_CYCLES(CSH2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .cmd(cmd2), .busy(busy2), .done(done2),
      .rx_data(rx_data2), .CS(CS2), .SCLK(SCLK2), .MOSI(MOSI2), .MISO(MISO2));

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%h expected 0x%h", name, cyc, act, exp);
      end
   endtask

   // Number of SCLK falls already seen at frame offset k, i.e. the cmd bit on MOSI.
   function automatic int bit_idx(input int k, input int h);
      int i;
      i = (k >= 1 + 2*h) ? ((k - 1 - 2*h) / (2*h) + 1) : 0;
      if (i > 31) i = 31;
      return i;
   endfunction

   // Expected {busy, done, CS, SCLK, MOSI} k cycles after the accept cycle.
   function automatic logic [4:0] model_pins(input bit active, input int k, input int h,
                                             input int csh, input logic [31:0] c);
      logic b, d, cs, sc, mo;
      int   p;
      b = 1'b0; d = 1'b0; cs = 1'b1; sc = 1'b0; mo = 1'b0;
      if (active && k >= 1) begin
         b = (k <= 65*h + csh);
         d = (k == 1 + 65*h);
         if (k <= 65*h) begin
            cs = 1'b0;
            p  = k - 1 - h;
            if (p >= 0 && p < 64*h) sc = ((p % (2*h)) < h);
            mo = c[31 - bit_idx(k, h)];
         end
      end
      return {b, d, cs, sc, mo};
   endfunction

   int          cyc = 0;
   bit          armed = 0;
   bit          m1_active = 0, m2_active = 0;
   int          m1_acc = 0, m2_acc = 0;
   logic [31:0] m1_cmd = '0, m2_cmd = '0, m1_miso = '0;
   logic [31:0] m1_rx = '0, m2_rx = '0;

   // Frame-level model: decides acceptance and when rx_data must change.
   initial begin
      int k;
      forever begin
         @(posedge clk);
         if (rst) begin
            m1_active = 0; m1_rx = '0;
            m2_active = 0; m2_rx = '0;
            armed = 1;
         end else begin
            k = cyc - m1_acc;
            if (!(m1_active && k >= 1 && k <= 65*H1 + CSH1) && start1) begin
               m1_active = 1; m1_acc = cyc; m1_cmd = cmd1; m1_miso = miso_word1;
            end else if (m1_active && k == 65*H1) begin
               m1_rx = m1_miso;
            end
            k = cyc - m2_acc;
            if (!(m2_active && k >= 1 && k <= 65*H2 + CSH2) && start2) begin
               m2_active = 1; m2_acc = cyc; m2_cmd = cmd2;
            end else if (m2_active && k == 65*H2) begin
               m2_rx = m2_cmd;
            end
         end
         cyc++;
      end
   end

   int          done1_k[$], done1_rises[$], done2_k[$], cs1_falls[$], cs2_falls[$], cs1_gaps[$];
   logic [31:0] done1_rx[$], done1_mosi[$], done2_rx[$];
   logic        cs1_prev = 1'b1, cs2_prev = 1'b1, sclk1_prev = 1'b0;
   int          rises1 = 0, cs1_gap = 0;
   bit          cs1_counting = 0;
   logic [31:0] mosi_cap1 = '0;

   // Per-cycle compare against the model, event recording, and MISO drive.
   initial begin
      logic [4:0] e;
      int k;
      forever begin
         @(negedge clk);
         if (armed) begin
            e = model_pins(m1_active, cyc - m1_acc, H1, CSH1, m1_cmd);
            chk1("busy1", busy1, e[4]); chk1("done1", done1, e[3]); chk1("cs1", CS1, e[2]);
            chk1("sclk1", SCLK1, e[1]); chk1("mosi1", MOSI1, e[0]);
            chk32("rx_data1", rx_data1, m1_rx);
            e = model_pins(m2_active, cyc - m2_acc, H2, CSH2, m2_cmd);
            chk1("busy2", busy2, e[4]); chk1("done2", done2, e[3]); chk1("cs2", CS2, e[2]);
            chk1("sclk2", SCLK2, e[1]); chk1("mosi2", MOSI2, e[0]);
            chk32("rx_data2", rx_data2, m2_rx);

            if (CS1 === 1'b0 && cs1_prev === 1'b1) begin
               cs1_falls.push_back(cyc);
               if (cs1_counting) cs1_gaps.push_back(cs1_gap);
               cs1_counting = 0; mosi_cap1 = '0; rises1 = 0;
            end
            if (CS1 === 1'b1 && cs1_prev === 1'b0) begin cs1_counting = 1; cs1_gap = 0; end
            if (CS1 === 1'b1 && busy1 === 1'b1 && cs1_counting) cs1_gap++;
            if (SCLK1 === 1'b1 && sclk1_prev === 1'b0) begin
               rises1++; mosi_cap1 = {mosi_cap1[30:0], MOSI1};
            end
            if (done1 === 1'b1) begin
               done1_k.push_back(cyc - m1_acc); done1_rx.push_back(rx_data1);
               done1_mosi.push_back(mosi_cap1); done1_rises.push_back(rises1);
            end
            if (CS2 === 1'b0 && cs2_prev === 1'b1) cs2_falls.push_back(cyc);
            if (done2 === 1'b1) begin done2_k.push_back(cyc - m2_acc); done2_rx.push_back(rx_data2); end
            cs1_prev = CS1; cs2_prev = CS2; sclk1_prev = SCLK1;
         end
         k = cyc - m1_acc;
         MISO1 = (m1_active && k >= 1 && k <= 65*H1) ? m1_miso[31 - bit_idx(k, H1)] : 1'b0;
      end
   end

   task automatic clear_log();
      done1_k.delete(); done1_rises.delete(); done1_rx.delete(); done1_mosi.delete();
      done2_k.delete(); done2_rx.delete(); cs1_falls.delete(); cs2_falls.delete(); cs1_gaps.delete();
   endtask

   task automatic frame1(input logic [31:0] c, input logic [31:0] m);
      cmd1 = c; miso_word1 = m; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; cmd1 = ~c;
   endtask

   initial begin
      rst = 1'b1; start1 = 1'b0; start2 = 1'b0; cmd1 = '0; cmd2 = '0; miso_word1 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      repeat (20) @(negedge clk);
      chk1("idle_cs", CS1, 1'b1); chk1("idle_sclk", SCLK1, 1'b0);
      chk1("idle_busy", busy1, 1'b0); chk32("idle_dones", done1_k.size(), 0);

      clear_log();
      frame1(32'hA5A50F0F, 32'h12340000);
      repeat (160) @(negedge clk);
      chk32("a_done_count", done1_k.size(), 1);
      if (done1_k.size() >= 1) begin
         chk32("a_done_cycle", done1_k[0], 131);
         chk32("a_rx", done1_rx[0], 32'h12340000);
         chk32("a_mosi", done1_mosi[0], 32'hA5A50F0F);
         chk32("a_rises", done1_rises[0], 32);
      end

      clear_log();
      cmd1 = 32'hFFFF0000; miso_word1 = 32'hCAFE0001; start1 = 1'b1;
      @(negedge clk);
      cmd1 = 32'h0000FFFF; miso_word1 = 32'h0001CAFE;
      repeat (139) @(negedge clk);
      start1 = 1'b0;
      repeat (160) @(negedge clk);
      chk32("b2b_done_count", done1_k.size(), 2);
      chk32("b2b_cs_falls", cs1_falls.size(), 2);
      if (cs1_falls.size() >= 2) chk32("b2b_period", cs1_falls[1] - cs1_falls[0], 139);
      if (cs1_gaps.size() >= 1) chk32("b2b_cs_gap", cs1_gaps[0], 8);
      if (done1_k.size() >= 2) begin
         chk32("b2b_mosi0", done1_mosi[0], 32'hFFFF0000);
         chk32("b2b_mosi1", done1_mosi[1], 32'h0000FFFF);
         chk32("b2b_rx0", done1_rx[0], 32'hCAFE0001);
         chk32("b2b_rx1", done1_rx[1], 32'h0001CAFE);
      end

      clear_log();
      frame1(32'h13579BDF, 32'h0F1E2D3C);
      repeat (49) @(negedge clk);
      start1 = 1'b1; cmd1 = 32'hFFFFFFFF;
      @(negedge clk);
      start1 = 1'b0;
      repeat (160) @(negedge clk);
      chk32("ign_done_count", done1_k.size(), 1);
      if (done1_k.size() >= 1) begin
         chk32("ign_done_cycle", done1_k[0], 131);
         chk32("ign_rx", done1_rx[0], 32'h0F1E2D3C);
         chk32("ign_mosi", done1_mosi[0], 32'h13579BDF);
      end

      clear_log();
      frame1(32'h0F0F0F0F, 32'h55AA33CC);
      repeat (69) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk1("rst_cs", CS1, 1'b1); chk1("rst_sclk", SCLK1, 1'b0);
      chk1("rst_busy", busy1, 1'b0); chk32("rst_rx", rx_data1, 32'h0);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      chk32("rst_no_done", done1_k.size(), 0);
      clear_log();
      frame1(32'h2468ACE0, 32'h89ABCDEF);
      repeat (160) @(negedge clk);
      chk32("post_rst_done_count", done1_k.size(), 1);
      if (done1_k.size() >= 1) begin
         chk32("post_rst_rx", done1_rx[0], 32'h89ABCDEF);
         chk32("post_rst_mosi", done1_mosi[0], 32'h2468ACE0);
      end

      clear_log();
      cmd2 = 32'hDEADBEEF; start2 = 1'b1;
      @(negedge clk);
      cmd2 = 32'h0BADF00D;
      repeat (67) @(negedge clk);
      start2 = 1'b0;
      repeat (90) @(negedge clk);
      chk32("fast_done_count", done2_k.size(), 2);
      chk32("fast_cs_falls", cs2_falls.size(), 2);
      if (done2_k.size() >= 2) begin
         chk32("fast_done_cycle", done2_k[0], 66);
         chk32("fast_rx0", done2_rx[0], 32'hDEADBEEF);
         chk32("fast_rx1", done2_rx[1], 32'h0BADF00D);
      end
      if (cs2_falls.size() >= 2) chk32("fast_period", cs2_falls[1] - cs2_falls[0], 67);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rhs_spi_master.md
# rhs_spi_master

SPI master for one RHS headstage. Each transaction clocks one 32-bit command word out on MOSI and captures one 32-bit result word from MISO. The block sits directly upstream of the headstage interface: it drives CS, SCLK and MOSI into the headstage and consumes its MISO stream. The acquisition sequencer above it issues one `start` per frame and collects `rx_data` on `done`.

## Interface
- CLK_DIV, 4: clk cycles per SCLK period. Must be even and ≥2. H = CLK_DIV/2 is the half-period.
- CS_HIGH_CYCLES, 8: minimum clk cycles CS stays high between frames. Must be ≥1.
- clk  in  1  single system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a frame; accepted only when busy=0
- cmd  in  32  command word; captured on the accept cycle
- busy  out  1  high from the accept cycle through the end of the CS-high gap
- done  out  1  one-cycle pulse; rx_data valid on this cycle
- rx_data  out  32  captured MISO word, MSB first; held until the next done
- CS  out  1  chip select, active low
- SCLK  out  1  serial clock, idle low
- MOSI  out  1  serial data to headstage
- MISO  in  1  serial data from headstage

## Operation
- All outputs are registered. Reset values: CS=1, SCLK=0, MOSI=0, busy=0, done=0, rx_data=0.
- FSM states:
  - IDLE: on start, go to SETUP.
  - SETUP: after H cycles, go to SHIFT.
  - SHIFT: after 32 SCLK periods, go to HOLD.
  - HOLD: after H cycles, go to GAP.
  - GAP: after CS_HIGH_CYCLES, go to IDLE.
- Accept: start=1 while in IDLE. cmd is latched into the TX shift register.
  - start during busy is ignored, not queued.
  - cmd changes after the accept cycle have no effect on the frame.
- SETUP: CS=0, SCLK=0, MOSI=cmd[31].
- SHIFT: each bit is H cycles SCLK high, then H cycles SCLK low.
  - On the clk edge that drives SCLK 1→0, MISO is shifted into the RX register LSB and MOSI advances to the next cmd bit.
  - After the 32nd capture, MOSI is held at cmd[0].
- HOLD: CS=0, SCLK=0.
- GAP: CS=1, SCLK=0, MOSI=0. done pulses on the first GAP cycle, and rx_data updates on that same cycle.
- Bit counter is 6 bits, 0..31. The phase counter counts 0..H-1. Neither wraps inside a frame.
- rst mid-frame: the next cycle returns all outputs to reset values and the FSM to IDLE. No done is issued, and the partial RX word is discarded.

## Timing
- Cycle 0 is the cycle where start is sampled in IDLE.
- Cycle 1: CS falls.
- Bit n (n=0..31): SCLK high on cycles 1+H+2Hn .. 2H+2Hn, falls on cycle 1+2H+2Hn.
- Last capture is on cycle 1+64H. CS rises and done pulses on cycle 1+65H; for CLK_DIV=4 that is cycle 131.
- busy falls on cycle 1+65H+CS_HIGH_CYCLES; for the defaults that is cycle 139.
- start on that same cycle is accepted. Back-to-back frame period = 1+65H+CS_HIGH_CYCLES clk cycles.
- SCLK duty cycle is exactly 50%. There are no SCLK edges while CS=1.

## Structure
- Package rhs_pkg holds:
  - FRAME_BITS=32
  - FSM state enum (IDLE, SETUP, SHIFT, HOLD, GAP)
  - RHS command opcode constants (CONVERT, READ, WRITE, CLEAR) used by the sequencer.
- Sub-module rhs_sclk_gen owns the H-cycle phase counter and the SCLK register. It emits one-cycle `rise` and `fall` strobes that the FSM uses for MOSI shifting and MISO capture.
- The master contains the FSM, bit counter, TX/RX shift registers and the gap counter.

## Test plan
- Reset, then idle for 20 cycles: CS=1, SCLK=0, MOSI=0, busy=0, done never pulses.
- start with cmd=0xA5A50F0F; bench drives MISO=0x12340000 MSB first, changing right after each SCLK fall:
  - MOSI bits sampled at SCLK rises equal 0xA5A50F0F
  - done pulses at cycle 131 with rx_data=0x12340000
  - exactly 32 SCLK rises occur.
- start held high continuously with cmd=0xFFFF0000, then 0x0000FFFF:
  - the second frame's CS falls exactly 139 cycles after the first
  - each frame captures its own cmd
  - CS is high for 8 cycles between frames.
- start pulsed at cycle 50 of an active frame: ignored, exactly one done, busy timing unchanged.
- rst asserted at cycle 70 of a frame: CS=1, SCLK=0, busy=0 on the next cycle, no done. A new start then completes normally with correct rx_data.
- CLK_DIV=2, CS_HIGH_CYCLES=1: MISO loopback of 0xDEADBEEF; done at cycle 66, rx_data=0xDEADBEEF, next frame accepted at cycle 67.
